// File: rtl/burst_mem_rr_arbiter.sv
// Round-robin arbiter sharing one burst memory port among NUM_REQ requesters, with per-requester burst-done.
// Grant and port muxing are combinational; acceptance is gated by out_wait_n, and write bursts stall while the owner drops in_wr.
module burst_mem_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            in_rd,
    input  logic [NUM_REQ-1:0]            in_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] in_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_din,
    output logic [DATA_WIDTH-1:0]         in_dout,
    output logic [NUM_REQ-1:0]            in_wait_n,
    output logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_burst_done,
    output logic                          out_rd,
    output logic                          out_wr,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic [DATA_WIDTH-1:0]         out_din,
    input  logic [DATA_WIDTH-1:0]         out_dout,
    input  logic                          out_wait_n,
    input  logic                          out_valid,
    output logic                          busy,
    output logic [2:0]                    grant_idx
);

    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                  r_state;
    logic [2:0]              r_ptr;
    logic [2:0]              r_sel;
    logic [CW-1:0]           r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;

    logic [NUM_REQ-1:0]      w_req;
    logic [2*NUM_REQ-1:0]    w_rot;
    logic [2:0]              w_gnt;
    logic                    w_gnt_vld;
    logic [NUM_REQ-1:0]      w_gnt_oh;
    logic [NUM_REQ-1:0]      w_sel_oh;
    logic                    w_g_wr;
    logic                    w_g_rd;
    logic                    w_s_wr;

    assign w_req = in_rd | in_wr;

    // Rotate so bit 0 is the requester right after the last winner; a 3-bit wrap of ptr+1 is already mod 8.
    assign w_rot = {w_req, w_req} >> (r_ptr + 3'd1);

    always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_gnt     = 3'((int'(r_ptr) + 1 + i) % NUM_REQ);
                w_gnt_vld = 1'b1;
            end
        end
    end

    assign w_gnt_oh = NUM_REQ'(1) << w_gnt;
    assign w_sel_oh = NUM_REQ'(1) << r_sel;
    assign w_g_wr   = |(in_wr & w_gnt_oh);
    assign w_g_rd   = |(in_rd & w_gnt_oh);
    assign w_s_wr   = |(in_wr & w_sel_oh);

    always_comb begin
        out_rd        = 1'b0;
        out_wr        = 1'b0;
        out_addr      = r_addr;
        out_din       = in_din[r_sel*DATA_WIDTH +: DATA_WIDTH];
        in_wait_n     = '0;
        in_valid      = '0;
        in_burst_done = '0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    out_addr  = in_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
                    out_din   = in_din[w_gnt*DATA_WIDTH +: DATA_WIDTH];
                    out_wr    = w_g_wr;
                    out_rd    = w_g_rd & ~w_g_wr;
                    in_wait_n = w_gnt_oh & {NUM_REQ{out_wait_n}};
                    if (BURST_LEN == 1 && w_g_wr && out_wait_n)
                        in_burst_done = w_gnt_oh;
                end else begin
                    out_addr  = '0;
                    in_wait_n = {NUM_REQ{out_wait_n}};
                end
            end
            READ: begin
                in_valid = w_sel_oh & {NUM_REQ{out_valid}};
                if (out_valid && r_cnt == LAST)
                    in_burst_done = w_sel_oh;
            end
            WRITE: begin
                out_wr    = w_s_wr;
                in_wait_n = w_sel_oh & {NUM_REQ{out_wait_n}};
                if (w_s_wr && out_wait_n && r_cnt == LAST)
                    in_burst_done = w_sel_oh;
            end
            default: ;
        endcase
        if (reset) begin
            out_rd        = 1'b0;
            out_wr        = 1'b0;
            in_wait_n     = '0;
            in_valid      = '0;
            in_burst_done = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= 3'(NUM_REQ - 1);
            r_sel   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld && out_wait_n) begin
                        r_sel  <= w_gnt;
                        r_ptr  <= w_gnt;
                        r_addr <= in_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
                        if (w_g_wr) begin
                            // The first write word goes out in the accept cycle itself.
                            r_cnt <= CW'(1);
                            if (BURST_LEN != 1)
                                r_state <= WRITE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= READ;
                        end
                    end
                end
                READ: begin
                    if (out_valid) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST)
                            r_state <= IDLE;
                    end
                end
                WRITE: begin
                    if (w_s_wr && out_wait_n) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST)
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_dout   = out_dout;
    assign busy      = (r_state != IDLE);
    assign grant_idx = r_sel;

endmodule
